// File: rtl/semaforo_panel.sv
// Manual-control front end for semaforo_design: button conditioning plus the
// auto/manual colour FSM. Define SEMAFORO_SAFE_SEQ_EN to force a yellow hold on green-to-red.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// AUTO       | semaforo_design sequences itself, red_m parked high
// MAN_RED    | manual, red requested
// MAN_YELLOW | manual, yellow requested
// MAN_GREEN  | manual, green requested
// MAN_TRANS  | manual, yellow forced for YELLOW_HOLD cycles before red
//            | (SEMAFORO_SAFE_SEQ_EN builds only)

module semaforo_panel #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int YELLOW_HOLD     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_mode,
  input  logic btn_green,
  input  logic btn_yellow,
  input  logic btn_red,
  output logic mainageability,
  output logic green_m,
  output logic yellow_m,
  output logic red_m
);

  if (DEBOUNCE_CYCLES < 2 || YELLOW_HOLD < 1) begin : g_bad_params
    $error("semaforo_panel: DEBOUNCE_CYCLES must be >= 2 and YELLOW_HOLD >= 1");
  end

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

  localparam int BM = 0;
  localparam int BG = 1;
  localparam int BY = 2;
  localparam int BR = 3;

  logic [3:0]    btn_raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    stable;
  logic [3:0]    press;
  logic [CW-1:0] cnt [4];

  assign btn_raw = {btn_red, btn_yellow, btn_green, btn_mode};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_TC) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Press fires in the same cycle the stable level is about to rise, so the
  // FSM moves together with the stable flop and only the output register follows.
  always_comb begin
    press = '0;
    for (int i = 0; i < 4; i++) begin
      press[i] = sync2[i] & ~stable[i] & (cnt[i] == CNT_TC);
    end
  end

`ifdef SEMAFORO_SAFE_SEQ_EN
  typedef enum logic [2:0] {
    AUTO       = 3'd0,
    MAN_RED    = 3'd1,
    MAN_YELLOW = 3'd2,
    MAN_GREEN  = 3'd3,
    MAN_TRANS  = 3'd4
  } state_t;

  localparam int HW = $clog2(YELLOW_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(YELLOW_HOLD - 1);

  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
`else
  typedef enum logic [2:0] {
    AUTO       = 3'd0,
    MAN_RED    = 3'd1,
    MAN_YELLOW = 3'd2,
    MAN_GREEN  = 3'd3
  } state_t;
`endif

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= AUTO;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef SEMAFORO_SAFE_SEQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
`ifdef SEMAFORO_SAFE_SEQ_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      AUTO: begin
        if (press[BM]) state_d = MAN_RED;
      end
      MAN_RED, MAN_YELLOW, MAN_GREEN: begin
        if (press[BM]) begin
          state_d = AUTO;
        end else if (press[BR]) begin
`ifdef SEMAFORO_SAFE_SEQ_EN
          if (state_q == MAN_GREEN) begin
            state_d = MAN_TRANS;
            hold_d  = HOLD_LOAD;
          end else begin
            state_d = MAN_RED;
          end
`else
          state_d = MAN_RED;
`endif
        end else if (press[BY]) begin
          state_d = MAN_YELLOW;
        end else if (press[BG]) begin
          state_d = MAN_GREEN;
        end
      end
`ifdef SEMAFORO_SAFE_SEQ_EN
      MAN_TRANS: begin
        if (press[BM]) begin
          state_d = AUTO;
        end else if (hold_q == '0) begin
          state_d = MAN_RED;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
`endif
      default: state_d = AUTO;
    endcase
  end

  logic man_d;
  logic green_d;
  logic yellow_d;
  logic red_d;

  always_comb begin
    man_d    = 1'b1;
    green_d  = 1'b0;
    yellow_d = 1'b0;
    red_d    = 1'b0;
    case (state_q)
      MAN_GREEN:  green_d  = 1'b1;
      MAN_YELLOW: yellow_d = 1'b1;
      MAN_RED:    red_d    = 1'b1;
`ifdef SEMAFORO_SAFE_SEQ_EN
      MAN_TRANS:  yellow_d = 1'b1;
`endif
      default: begin
        man_d = 1'b0;
        red_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mainageability <= 1'b0;
      green_m        <= 1'b0;
      yellow_m       <= 1'b0;
      red_m          <= 1'b1;
    end else begin
      mainageability <= man_d;
      green_m        <= green_d;
      yellow_m       <= yellow_d;
      red_m          <= red_d;
    end
  end

endmodule

// File: tb/tb_semaforo_panel.sv
// Directed bench for semaforo_panel with DEBOUNCE_CYCLES=4, YELLOW_HOLD=3.
// Outputs are packed as {mainageability, green_m, yellow_m, red_m}.

module tb_semaforo_panel;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] btns = 4'b0000;   // {red, yellow, green, mode}
  logic mainageability, green_m, yellow_m, red_m;
  logic [3:0] outs;
  logic mon_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int green_rises = 0;

  localparam logic [3:0] B_MODE = 4'b0001;
  localparam logic [3:0] B_GRN  = 4'b0010;
  localparam logic [3:0] B_YEL  = 4'b0100;
  localparam logic [3:0] B_RED  = 4'b1000;

  localparam logic [3:0] O_AUTO = 4'b0001;
  localparam logic [3:0] O_MRED = 4'b1001;
  localparam logic [3:0] O_MYEL = 4'b1010;
  localparam logic [3:0] O_MGRN = 4'b1100;

  semaforo_panel #(.DEBOUNCE_CYCLES(4), .YELLOW_HOLD(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_mode       (btns[0]),
    .btn_green      (btns[1]),
    .btn_yellow     (btns[2]),
    .btn_red        (btns[3]),
    .mainageability (mainageability),
    .green_m        (green_m),
    .yellow_m       (yellow_m),
    .red_m          (red_m)
  );

  assign outs = {mainageability, green_m, yellow_m, red_m};

  always #5 clk = ~clk;

  always @(posedge green_m) green_rises++;

  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp++;
      if ($countones({green_m, yellow_m, red_m}) != 1) begin
        n_bad++;
        $display("FAIL onehot: got g/y/r=%b%b%b want exactly one high", green_m, yellow_m, red_m);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic after_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press_btns(input logic [3:0] mask, input int hold);
    tick(1);
    btns = mask;
    tick(hold);
    btns = 4'b0000;
    tick(12);
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    btns = 4'b0000;
    tick(3);
    @(negedge clk);
    n_cmp++;
    if (outs !== O_AUTO) begin
      n_bad++;
      $display("FAIL reset_state: got %b want %b", outs, O_AUTO);
    end
    mon_en = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_async_reset_and_latency;
    press_btns(B_MODE, 6);
    n_cmp++;
    if (outs !== O_MRED) begin
      n_bad++;
      $display("FAIL enter_manual: got %b want %b", outs, O_MRED);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if (outs !== O_AUTO) begin
      n_bad++;
      $display("FAIL async_reset: got %b want %b", outs, O_AUTO);
    end
    tick(2);
    rst = 1'b0;
    tick(2);
    btns = B_MODE;
    after_edges(6);
    n_cmp++;
    if (outs !== O_AUTO) begin
      n_bad++;
      $display("FAIL latency_edge6: got %b want %b", outs, O_AUTO);
    end
    after_edges(1);
    n_cmp++;
    if (outs !== O_MRED) begin
      n_bad++;
      $display("FAIL latency_edge7: got %b want %b", outs, O_MRED);
    end
    after_edges(3);
    btns = 4'b0000;
    tick(12);
  endtask

  task automatic test_glitch_and_hold;
    int rises0;
    press_btns(B_GRN, 3);
    n_cmp++;
    if (outs !== O_MRED) begin
      n_bad++;
      $display("FAIL glitch_ignored: got %b want %b", outs, O_MRED);
    end
    rises0 = green_rises;
    press_btns(B_GRN, 6);
    n_cmp++;
    if (outs !== O_MGRN) begin
      n_bad++;
      $display("FAIL green_press: got %b want %b", outs, O_MGRN);
    end
    n_cmp++;
    if (green_rises - rises0 != 1) begin
      n_bad++;
      $display("FAIL green_single: got %0d rises want 1", green_rises - rises0);
    end
  endtask

  task automatic test_priority;
    press_btns(B_RED | B_GRN, 6);
    n_cmp++;
    if (outs !== O_MRED) begin
      n_bad++;
      $display("FAIL red_over_green: got %b want %b", outs, O_MRED);
    end
    press_btns(B_YEL | B_MODE, 6);
    n_cmp++;
    if (outs !== O_AUTO) begin
      n_bad++;
      $display("FAIL mode_over_yellow: got %b want %b", outs, O_AUTO);
    end
  endtask

  task automatic test_auto_ignores_colour;
    press_btns(B_YEL, 6);
    n_cmp++;
    if (outs !== O_AUTO) begin
      n_bad++;
      $display("FAIL auto_yellow_ignored: got %b want %b", outs, O_AUTO);
    end
    press_btns(B_MODE, 6);
    n_cmp++;
    if (outs !== O_MRED) begin
      n_bad++;
      $display("FAIL auto_to_man_red: got %b want %b", outs, O_MRED);
    end
  endtask

  task automatic go_green;
    press_btns(B_GRN, 6);
    n_cmp++;
    if (outs !== O_MGRN) begin
      n_bad++;
      $display("FAIL go_green: got %b want %b", outs, O_MGRN);
    end
  endtask

`ifdef SEMAFORO_SAFE_SEQ_EN
  task automatic test_safe_seq;
    go_green();
    tick(1);
    btns = B_RED;
    after_edges(6);
    n_cmp++;
    if (outs !== O_MGRN) begin
      n_bad++;
      $display("FAIL trans_edge6: got %b want %b", outs, O_MGRN);
    end
    for (int k = 7; k <= 9; k++) begin
      after_edges(1);
      n_cmp++;
      if (outs !== O_MYEL) begin
        n_bad++;
        $display("FAIL trans_yellow_e%0d: got %b want %b", k, outs, O_MYEL);
      end
    end
    after_edges(1);
    n_cmp++;
    if (outs !== O_MRED) begin
      n_bad++;
      $display("FAIL trans_to_red: got %b want %b", outs, O_MRED);
    end
    btns = 4'b0000;
    tick(12);

    go_green();
    tick(1);
    btns = B_RED;
    tick(2);
    btns = B_RED | B_GRN;
    after_edges(5);
    for (int k = 7; k <= 9; k++) begin
      n_cmp++;
      if (outs !== O_MYEL) begin
        n_bad++;
        $display("FAIL hold_green_e%0d: got %b want %b", k, outs, O_MYEL);
      end
      after_edges(1);
    end
    n_cmp++;
    if (outs !== O_MRED) begin
      n_bad++;
      $display("FAIL hold_green_red: got %b want %b", outs, O_MRED);
    end
    btns = 4'b0000;
    tick(12);
    n_cmp++;
    if (outs !== O_MRED) begin
      n_bad++;
      $display("FAIL hold_green_settled: got %b want %b", outs, O_MRED);
    end

    go_green();
    tick(1);
    btns = B_RED;
    tick(1);
    btns = B_RED | B_MODE;
    after_edges(6);
    n_cmp++;
    if (outs !== O_MYEL) begin
      n_bad++;
      $display("FAIL hold_mode_e7: got %b want %b", outs, O_MYEL);
    end
    after_edges(1);
    n_cmp++;
    if (outs !== O_AUTO) begin
      n_bad++;
      $display("FAIL hold_mode_auto: got %b want %b", outs, O_AUTO);
    end
    btns = 4'b0000;
    tick(12);
    n_cmp++;
    if (outs !== O_AUTO) begin
      n_bad++;
      $display("FAIL hold_mode_settled: got %b want %b", outs, O_AUTO);
    end
  endtask
`else
  task automatic test_direct_red;
    go_green();
    tick(1);
    btns = B_RED;
    after_edges(6);
    n_cmp++;
    if (outs !== O_MGRN) begin
      n_bad++;
      $display("FAIL direct_edge6: got %b want %b", outs, O_MGRN);
    end
    after_edges(1);
    n_cmp++;
    if (outs !== O_MRED) begin
      n_bad++;
      $display("FAIL direct_edge7: got %b want %b", outs, O_MRED);
    end
    after_edges(1);
    n_cmp++;
    if (outs !== O_MRED) begin
      n_bad++;
      $display("FAIL direct_edge8: got %b want %b", outs, O_MRED);
    end
    btns = 4'b0000;
    tick(12);
    press_btns(B_MODE, 6);
    n_cmp++;
    if (outs !== O_AUTO) begin
      n_bad++;
      $display("FAIL direct_back_to_auto: got %b want %b", outs, O_AUTO);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_async_reset_and_latency();
    test_glitch_and_hold();
    test_priority();
    test_auto_ignores_colour();
`ifdef SEMAFORO_SAFE_SEQ_EN
    test_safe_seq();
`else
    test_direct_red();
`endif
    tick(2);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
